// File: rtl/audio_comb_sched_pkg.sv
// Shared types and width helpers for the time-multiplexed comb scheduler.
package audio_comb_sched_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Width that never collapses to zero bits, for pointers and addresses.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/audio_comb_rr_arb.sv
// Combinational round-robin arbiter: first requester after the last grant, cyclically.
module audio_comb_rr_arb
    import audio_comb_sched_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    localparam int unsigned CHW = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] last,
    output logic [NCH-1:0] gnt_c,
    output logic [CHW-1:0] gnt_idx_c,
    output logic           any_c
);

    logic           any_hi, any_lo;
    logic [CHW-1:0] idx_hi, idx_lo;

    // Channels above the last grant win over channels at or below it.
    always_comb begin
        any_hi = 1'b0;
        any_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (req[c] && (c > 32'(last)) && !any_hi) begin
                any_hi = 1'b1;
                idx_hi = CHW'(c);
            end
            if (req[c] && (c <= 32'(last)) && !any_lo) begin
                any_lo = 1'b1;
                idx_lo = CHW'(c);
            end
        end
    end

    always_comb begin
        any_c     = any_hi | any_lo;
        gnt_idx_c = any_hi ? idx_hi : idx_lo;
        gnt_c     = any_c ? (NCH'(1) << gnt_idx_c) : '0;
    end

endmodule

// File: rtl/audio_comb_sched.sv
// Shared comb datapath (y = x[n] - x[n-DEPTH]) scheduled across NCH channels.
// Optional: define AUDIO_COMB_SCHED_SAT_EN to saturate the difference instead of wrapping.
module audio_comb_sched
    import audio_comb_sched_pkg::*;
#(
    parameter  int unsigned IW    = 16,
    parameter  int unsigned DEPTH = 1,
    parameter  int unsigned NCH   = 4,
    localparam int unsigned CHW   = clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*IW-1:0] snd_in,
    output logic [NCH-1:0]    ack,
    output logic              busy,
    output logic              out_valid,
    output logic [CHW-1:0]    out_ch,
    output logic [IW-1:0]     snd_out
);

    localparam int unsigned PW     = clog2_min1(DEPTH);
    localparam int unsigned NWORDS = NCH * DEPTH;
    localparam int unsigned RAW    = clog2_min1(NWORDS);

    state_e          state, state_n;
    logic [RAW-1:0]  clr_cnt;
    logic [CHW-1:0]  last_g, g_q;
    logic [PW-1:0]   ptr [NCH];
    logic [IW-1:0]   x_q, prev, ram_q, res_c;
    logic [IW-1:0]   ram [NWORDS];
    logic [IW-1:0]   snd_arr [NCH];

    logic [NCH-1:0]  gnt_c;
    logic [CHW-1:0]  gidx_c;
    logic            any_c;
    logic            ram_we_c, ram_re_c;
    logic [RAW-1:0]  ram_addr_c;
    logic [IW-1:0]   ram_wdata_c;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        assign snd_arr[c] = snd_in[c*IW +: IW];
    end

    audio_comb_rr_arb #(.NCH(NCH)) u_arb (
        .req       (req),
        .last      (last_g),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gidx_c),
        .any_c     (any_c)
    );

`ifdef AUDIO_COMB_SCHED_SAT_EN
    logic [IW:0] diff_c;
    assign diff_c = {x_q[IW-1], x_q} - {prev[IW-1], prev};
    // Sign bits disagree only when the IW-bit result overflowed.
    always_comb begin
        if (diff_c[IW] != diff_c[IW-1])
            res_c = diff_c[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        else
            res_c = diff_c[IW-1:0];
    end
`else
    assign res_c = x_q - prev;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_CLEAR;
        else       state <= state_n;
    end

    // Next state and single-port RAM control; delay line of channel c starts at c*DEPTH.
    always_comb begin
        state_n     = state;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        case (state)
            ST_CLEAR: begin
                ram_we_c   = 1'b1;
                ram_addr_c = clr_cnt;
                if (clr_cnt == RAW'(NWORDS - 1)) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_c) begin
                    ram_re_c   = 1'b1;
                    ram_addr_c = RAW'(32'(gidx_c) * DEPTH + 32'(ptr[gidx_c]));
                    state_n    = ST_RD;
                end
            end
            ST_RD: state_n = ST_WR;
            ST_WR: begin
                ram_we_c    = 1'b1;
                ram_addr_c  = RAW'(32'(g_q) * DEPTH + 32'(ptr[g_q]));
                ram_wdata_c = x_q;
                state_n     = ST_IDLE;
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we_c) ram[ram_addr_c] <= ram_wdata_c;
        if (ram_re_c) ram_q <= ram[ram_addr_c];
    end

    // Datapath, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt   <= '0;
            last_g    <= CHW'(NCH - 1);
            g_q       <= '0;
            x_q       <= '0;
            prev      <= '0;
            ack       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            snd_out   <= '0;
            busy      <= 1'b1;
            ptr       <= '{default: '0};
        end else begin
            ack       <= '0;
            out_valid <= 1'b0;
            busy      <= (state_n != ST_IDLE);
            case (state)
                ST_CLEAR: clr_cnt <= clr_cnt + RAW'(1);
                ST_IDLE: begin
                    if (any_c) begin
                        ack    <= gnt_c;
                        g_q    <= gidx_c;
                        last_g <= gidx_c;
                        x_q    <= snd_arr[gidx_c];
                    end
                end
                ST_RD: prev <= ram_q;
                ST_WR: begin
                    out_valid  <= 1'b1;
                    out_ch     <= g_q;
                    snd_out    <= res_c;
                    ptr[g_q]   <= (ptr[g_q] == PW'(DEPTH - 1)) ? '0 : ptr[g_q] + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_comb_sched.sv
// Bench for audio_comb_sched: directed steps plus randomized traffic against a per-channel history model.
module tb_audio_comb_sched;

    localparam int NCH   = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req;
    logic [15:0] tb_in [NCH];
    logic [63:0] snd_in;
    logic [3:0]  ack;
    logic        busy, out_valid;
    logic [1:0]  out_ch;
    logic [15:0] snd_out;

    logic [1:0]  b_req;
    logic [31:0] b_snd_in;
    logic [1:0]  b_ack;
    logic        b_busy, b_out_valid;
    logic        b_out_ch;
    logic [15:0] b_snd_out;

    always #5 clk = ~clk;
    assign snd_in = {tb_in[3], tb_in[2], tb_in[1], tb_in[0]};

    audio_comb_sched #(.IW(16), .DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk(clk), .reset(reset), .req(req), .snd_in(snd_in), .ack(ack), .busy(busy),
        .out_valid(out_valid), .out_ch(out_ch), .snd_out(snd_out)
    );

    audio_comb_sched #(.IW(16), .DEPTH(1), .NCH(2)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .snd_in(b_snd_in), .ack(b_ack), .busy(b_busy),
        .out_valid(b_out_valid), .out_ch(b_out_ch), .snd_out(b_snd_out)
    );

    typedef struct {
        int          ch;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_m;
    bit          withdraw_en = 1'b0;
    bit          gap_en = 1'b0;
    logic [15:0] stim    [NCH][$];
    logic [15:0] hist    [NCH][$];
    logic [15:0] out_log [NCH][$];
    exp_t        efifo[$];
    int          ack_cyc[$];
    logic [3:0]  ack_val[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference comb: current sample minus the one DEPTH samples earlier on that channel.
    function automatic logic [15:0] comb_ref(input logic [15:0] x, input logic [15:0] p);
        int d;
        d = int'($signed(x)) - int'($signed(p));
`ifdef AUDIO_COMB_SCHED_SAT_EN
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
`endif
        return 16'(d);
    endfunction

    function automatic int rr_pick(input logic [3:0] r);
        for (int k = 1; k <= NCH; k++) begin
            if (r[(last_m + k) % NCH]) return (last_m + k) % NCH;
        end
        return -1;
    endfunction

    function automatic bit pending();
        bit p;
        p = (req != 4'd0) || (efifo.size() != 0);
        for (int c = 0; c < NCH; c++) if (stim[c].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        efifo.delete();
        ack_cyc.delete();
        ack_val.delete();
        for (int c = 0; c < NCH; c++) begin
            hist[c].delete();
            out_log[c].delete();
            for (int k = 0; k < DEPTH; k++) hist[c].push_back(16'd0);
        end
        last_m = NCH - 1;
    endtask

    // One clock: observe ack/out_valid, then let requesters react.
    task automatic step();
        int          g;
        exp_t        e;
        logic [15:0] x;
        @(posedge clk);
        #1;
        cyc++;
        if (ack !== 4'd0) begin
            g = rr_pick(req);
            check("ack_grant", 32'(ack), (g < 0) ? 32'd0 : (32'd1 << g));
            ack_cyc.push_back(cyc);
            ack_val.push_back(ack);
            if (g >= 0) begin
                x     = tb_in[g];
                e.ch  = g;
                e.val = comb_ref(x, hist[g].pop_front());
                e.cyc = cyc;
                hist[g].push_back(x);
                efifo.push_back(e);
                last_m = g;
                req[g] = 1'b0;
            end
        end
        if (out_valid === 1'b1) begin
            if (efifo.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = efifo.pop_front();
                check("out_ch", 32'(out_ch), 32'(e.ch));
                check("snd_out", 32'(snd_out), 32'(e.val));
                check("latency", 32'(cyc - e.cyc), 32'd2);
                out_log[out_ch].push_back(snd_out);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (withdraw_en && req[c] && $urandom_range(15) == 0) req[c] = 1'b0;
            if (!req[c] && stim[c].size() != 0 && (!gap_en || $urandom_range(1) == 1)) begin
                tb_in[c] = stim[c].pop_front();
                req[c]   = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        int n, b_n;
        reset = 1'b1;
        model_reset();
        step();
        step();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_snd_out", 32'(snd_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_b_busy", 32'(b_busy), 32'd1);
        reset = 1'b0;
        cyc   = 0;
        n     = 0;
        b_n   = -1;
        while (busy && n < 100) begin
            step();
            n++;
            if (!b_busy && b_n < 0) b_n = n;
            check("ack_in_clear", 32'(ack), 32'd0);
        end
        check("clear_len", 32'(n), 32'(NCH * DEPTH));
        check("b_clear_len", 32'(b_n), 32'd2);
    endtask

    task automatic run_drain(input int bound);
        int n;
        n = 0;
        while (pending() && n < bound) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(pending()), 32'd0);
    endtask

    initial begin
        logic [3:0]  exp_seq [5];
        logic [15:0] exp_v   [4];
        logic [15:0] bv      [3];
        logic [15:0] be      [3];
        logic [15:0] v;
        int          n;

        req      = 4'd0;
        b_req    = 2'd0;
        b_snd_in = 32'd0;
        for (int c = 0; c < NCH; c++) tb_in[c] = 16'd0;

        // All channels requesting through reset: CLEAR, then strict rotation 3 cycles apart.
        for (int c = 0; c < NCH; c++) begin
            stim[c].push_back(16'($urandom));
            stim[c].push_back(16'($urandom));
        end
        do_reset();
        run_drain(200);
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("ack_count", 32'(ack_val.size()), 32'd8);
        if (ack_val.size() >= 5) begin
            check("first_ack_cyc", 32'(ack_cyc[0]), 32'(NCH * DEPTH + 1));
            for (int i = 0; i < 5; i++) begin
                check("ack_seq", 32'(ack_val[i]), 32'(exp_seq[i]));
                if (i > 0) check("ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
            end
        end

        // Channel 0 alone.
        do_reset();
        stim[0] = '{16'd100, 16'd200, 16'd300, 16'd400};
        run_drain(200);
        exp_v = '{16'd100, 16'd200, 16'd200, 16'd200};
        check("ch0_count", 32'(out_log[0].size()), 32'd4);
        if (out_log[0].size() == 4)
            for (int i = 0; i < 4; i++) check("ch0_result", 32'(out_log[0][i]), 32'(exp_v[i]));

        // Channels 0 and 2 interleaved.
        do_reset();
        stim[0] = '{16'd10, 16'd20, 16'd30};
        stim[2] = '{16'hFFFB, 16'hFFFB, 16'd7};
        run_drain(200);
        check("ch0_ilv_count", 32'(out_log[0].size()), 32'd3);
        check("ch2_ilv_count", 32'(out_log[2].size()), 32'd3);
        if (out_log[0].size() == 3 && out_log[2].size() == 3) begin
            check("ch0_ilv_2", 32'(out_log[0][2]), 32'd20);
            check("ch2_ilv_0", 32'(out_log[2][0]), 32'hFFFB);
            check("ch2_ilv_1", 32'(out_log[2][1]), 32'hFFFB);
            check("ch2_ilv_2", 32'(out_log[2][2]), 32'd12);
        end

        // Overflow corner on channel 1.
        do_reset();
        stim[1] = '{16'h8000, 16'h0000, 16'h7FFF};
        run_drain(200);
        check("ovf_count", 32'(out_log[1].size()), 32'd3);
        if (out_log[1].size() == 3) begin
            check("ovf_0", 32'(out_log[1][0]), 32'h8000);
            check("ovf_1", 32'(out_log[1][1]), 32'h0000);
`ifdef AUDIO_COMB_SCHED_SAT_EN
            check("ovf_2", 32'(out_log[1][2]), 32'h7FFF);
`else
            check("ovf_2", 32'(out_log[1][2]), 32'hFFFF);
`endif
        end

        // Reset while the sample sits in RD: dropped without out_valid.
        do_reset();
        stim[0] = '{16'd77};
        n = 0;
        while (ack_val.size() == 0 && n < 50) begin
            step();
            n++;
        end
        check("mid_ack_seen", 32'(ack_val.size()), 32'd1);
        do_reset();
        stim[0] = '{16'd50};
        run_drain(200);
        check("post_rst_count", 32'(out_log[0].size()), 32'd1);
        if (out_log[0].size() == 1) check("post_rst_result", 32'(out_log[0][0]), 32'd50);

        // Random traffic with gaps and withdrawn requests.
        do_reset();
        withdraw_en = 1'b1;
        gap_en      = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(7))
                0:       v = 16'h8000;
                1:       v = 16'h7FFF;
                default: v = 16'($urandom);
            endcase
            stim[$urandom_range(NCH - 1)].push_back(v);
        end
        run_drain(20000);
        withdraw_en = 1'b0;
        gap_en      = 1'b0;

        // DEPTH=1, NCH=2 instance: channel 1 only.
        do_reset();
        bv = '{16'd5, 16'd9, 16'd9};
        be = '{16'd5, 16'd4, 16'd0};
        for (int i = 0; i < 3; i++) begin
            b_snd_in = {bv[i], 16'h1234};
            b_req    = 2'b10;
            n = 0;
            while (b_ack == 2'b00 && n < 30) begin
                step();
                n++;
            end
            check("b_ack", 32'(b_ack), 32'b10);
            b_req    = 2'b00;
            b_snd_in = 32'hDEAD_BEEF;
            n = 0;
            while (!b_out_valid && n < 10) begin
                step();
                n++;
            end
            check("b_latency", 32'(n), 32'd2);
            check("b_out_ch", 32'(b_out_ch), 32'd1);
            check("b_snd_out", 32'(b_snd_out), 32'(be[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
